// File: rtl/sbox_nibble_scheduler_if.sv
// Handshake bundle between the round controller / PRNG and the S-box nibble scheduler.
// The scheduler is the slave: it receives start/rnd_valid and drives everything else.
interface sbox_nibble_scheduler_if #(
    parameter int NUM_NIBBLES = 16,
    parameter int NUM_STEPS   = 4
);
    localparam int IDXW = $clog2(NUM_NIBBLES);

    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 rnd_valid;
    logic                 rnd_ready;
    logic                 sb_in_valid;
    logic [IDXW-1:0]      sb_in_idx;
    logic [NUM_STEPS-1:0] step_en;
    logic                 wr_en;
    logic [IDXW-1:0]      wr_idx;

    modport master (
        output start, rnd_valid,
        input  busy, done, rnd_ready, sb_in_valid, sb_in_idx, step_en, wr_en, wr_idx
    );

    modport slave (
        input  start, rnd_valid,
        output busy, done, rnd_ready, sb_in_valid, sb_in_idx, step_en, wr_en, wr_idx
    );
endinterface

// File: rtl/sbox_nibble_scheduler.sv
// Feeds the nibbles of one round through a shared pipelined masked S-box chain, one per
// cycle when fresh randomness is available, and tracks them to write-back with a token pipe.
module sbox_nibble_scheduler #(
    parameter int NUM_NIBBLES  = 16,
    parameter int NUM_STEPS    = 4,
    parameter int STEP_LATENCY = 2,
    parameter int RAND_BITS    = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    sbox_nibble_scheduler_if.slave bus
);
    localparam int IDXW      = $clog2(NUM_NIBBLES);
    localparam int CNTW      = $clog2(NUM_NIBBLES + 1);
    localparam int TOTAL_LAT = NUM_STEPS * STEP_LATENCY;
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NUM_NIBBLES - 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(NUM_NIBBLES);

    if (RAND_BITS < 1 || TOTAL_LAT < 1) begin : g_param_chk
        $error("sbox_nibble_scheduler: RAND_BITS and NUM_STEPS*STEP_LATENCY must be >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_e;

    state_e                          state_q, state_d;
    logic [CNTW-1:0]                 issue_cnt_q, issue_cnt_d;
    logic [CNTW-1:0]                 wr_cnt_q, wr_cnt_d;
    logic [IDXW-1:0]                 last_idx_q, last_idx_d;
    logic [TOTAL_LAT-1:0]            vld_pipe_q;
    logic [TOTAL_LAT-1:0][IDXW-1:0]  idx_pipe_q;
    logic                            issue;
    logic                            wr_last;
    logic [IDXW-1:0]                 in_idx;
    logic [NUM_STEPS-1:0]            step_en;

    // Randomness is consumed exactly when a nibble enters the chain.
    assign issue   = (state_q == S_FEED) && bus.rnd_valid;
    assign in_idx  = issue ? issue_cnt_q[IDXW-1:0] : last_idx_q;
    assign wr_last = vld_pipe_q[TOTAL_LAT-1] && (wr_cnt_q == LAST_CNT);

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        last_idx_d  = last_idx_q;

        if (vld_pipe_q[TOTAL_LAT-1] && (wr_cnt_q != FULL_CNT)) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d     = S_FEED;
                    issue_cnt_d = '0;
                    wr_cnt_d    = '0;
                end
            end
            S_FEED: begin
                if (issue) begin
                    last_idx_d = issue_cnt_q[IDXW-1:0];
                    if (issue_cnt_q != FULL_CNT) issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_cnt_q == LAST_CNT) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (wr_last) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            wr_cnt_q    <= '0;
            last_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            last_idx_q  <= last_idx_d;
        end
    end

    // The chain never stalls, so the token pipe shifts unconditionally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe_q <= '0;
            idx_pipe_q <= '0;
        end else begin
            vld_pipe_q[0] <= issue;
            idx_pipe_q[0] <= in_idx;
            for (int i = 1; i < TOTAL_LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                idx_pipe_q[i] <= idx_pipe_q[i-1];
            end
        end
    end

    for (genvar s = 0; s < NUM_STEPS; s++) begin : g_step
        if (s == 0) begin : g_first
            assign step_en[s] = issue | (|vld_pipe_q[0 +: STEP_LATENCY]);
        end else begin : g_rest
            assign step_en[s] = |vld_pipe_q[s*STEP_LATENCY +: STEP_LATENCY];
        end
    end

    assign bus.busy        = (state_q == S_FEED) || (state_q == S_DRAIN);
    assign bus.done        = (state_q == S_DONE);
    assign bus.rnd_ready   = issue;
    assign bus.sb_in_valid = issue;
    assign bus.sb_in_idx   = in_idx;
    assign bus.step_en     = step_en;
    assign bus.wr_en       = vld_pipe_q[TOTAL_LAT-1];
    assign bus.wr_idx      = idx_pipe_q[TOTAL_LAT-1];
endmodule

// File: tb/tb_sbox_nibble_scheduler.sv
// Bench: two schedulers (STEP_LATENCY 1 and 2) share the stimulus and are compared against a
// token-age reference model plus fixed timing expectations.
module tb_sbox_nibble_scheduler;
    localparam int N  = 16;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic rnd_valid = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    sbox_nibble_scheduler_if #(.NUM_NIBBLES(N), .NUM_STEPS(NS)) ifa ();
    sbox_nibble_scheduler_if #(.NUM_NIBBLES(N), .NUM_STEPS(NS)) ifb ();

    assign ifa.start = start;
    assign ifa.rnd_valid = rnd_valid;
    assign ifb.start = start;
    assign ifb.rnd_valid = rnd_valid;

    sbox_nibble_scheduler #(.NUM_NIBBLES(N), .NUM_STEPS(NS), .STEP_LATENCY(1), .RAND_BITS(4))
        dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
    sbox_nibble_scheduler #(.NUM_NIBBLES(N), .NUM_STEPS(NS), .STEP_LATENCY(2), .RAND_BITS(4))
        dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(int d);
        return (d == 0) ? 4 : 8;
    endfunction
    function automatic int sl_of(int d);
        return (d == 0) ? 1 : 2;
    endfunction

    // Observed outputs, gathered per DUT
    logic          o_valid[2], o_rdy[2], o_wr[2], o_done[2], o_busy[2];
    logic [3:0]    o_idx[2], o_widx[2];
    logic [NS-1:0] o_step[2];
    logic [12:0]   got[2];

    assign o_valid[0] = ifa.sb_in_valid;  assign o_valid[1] = ifb.sb_in_valid;
    assign o_rdy[0]   = ifa.rnd_ready;    assign o_rdy[1]   = ifb.rnd_ready;
    assign o_wr[0]    = ifa.wr_en;        assign o_wr[1]    = ifb.wr_en;
    assign o_done[0]  = ifa.done;         assign o_done[1]  = ifb.done;
    assign o_busy[0]  = ifa.busy;         assign o_busy[1]  = ifb.busy;
    assign o_idx[0]   = ifa.sb_in_idx;    assign o_idx[1]   = ifb.sb_in_idx;
    assign o_widx[0]  = ifa.wr_idx;       assign o_widx[1]  = ifb.wr_idx;
    assign o_step[0]  = ifa.step_en;      assign o_step[1]  = ifb.step_en;

    always_comb begin
        for (int d = 0; d < 2; d++)
            got[d] = {o_busy[d], o_done[d], o_valid[d], o_rdy[d], o_idx[d], o_step[d], o_wr[d]};
    end

    // Reference model: a round is "running" until its last nibble is written; each issued
    // nibble is remembered by issue cycle, and everything else follows from token age.
    bit            m_run[2], m_done[2];
    int            m_issued[2], m_last[2];
    int            m_iss_t[2][N];
    bit            e_valid[2], e_wr[2];
    int            e_widx[2];
    logic [NS-1:0] e_step[2];
    logic [12:0]   expv[2];
    int            age;

    always_comb begin
        age = 0;
        for (int d = 0; d < 2; d++) begin
            e_valid[d] = m_run[d] && (m_issued[d] < N) && rnd_valid;
            e_wr[d]    = 1'b0;
            e_widx[d]  = 0;
            e_step[d]  = '0;
            e_step[d][0] = e_valid[d];
            for (int k = 0; k < N; k++) begin
                if (k < m_issued[d]) begin
                    age = cyc - m_iss_t[d][k];
                    if (age == lat_of(d)) begin
                        e_wr[d]   = 1'b1;
                        e_widx[d] = k;
                    end
                    for (int s = 0; s < NS; s++)
                        if (age - 1 >= s * sl_of(d) && age - 1 < (s + 1) * sl_of(d))
                            e_step[d][s] = 1'b1;
                end
            end
            expv[d] = {m_run[d], m_done[d], e_valid[d], e_valid[d],
                       4'(e_valid[d] ? m_issued[d] : m_last[d]), e_step[d], e_wr[d]};
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_run[d]    <= 1'b0;
                m_done[d]   <= 1'b0;
                m_issued[d] <= 0;
                m_last[d]   <= 0;
            end else begin
                m_done[d] <= e_wr[d] && (e_widx[d] == N - 1);
                if (e_wr[d] && (e_widx[d] == N - 1)) begin
                    m_run[d] <= 1'b0;
                end else if (!m_run[d] && !m_done[d] && start) begin
                    m_run[d]    <= 1'b1;
                    m_issued[d] <= 0;
                end
                if (e_valid[d]) begin
                    m_iss_t[d][m_issued[d]] <= cyc;
                    m_issued[d] <= m_issued[d] + 1;
                    m_last[d]   <= m_issued[d];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rnd_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({got[d], o_widx[d]} !== 17'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got %h exp 0", d, {got[d], o_widx[d]});
            end
        end
        tick();
        rst = 1'b0;
    endtask

    // STEP_LATENCY=1 DUT against fixed cycle numbers; the other DUT against the model.
    task automatic test_latency1();
        bit ev, ew;
        for (int c = 0; c < 28; c++) begin
            start = (c == 0); rnd_valid = 1'b1;
            @(negedge clk);
            ev = (c >= 1 && c <= 16);
            ew = (c >= 5 && c <= 20);
            checks++;
            if ({ifa.busy, ifa.done, ifa.sb_in_valid, ifa.wr_en} !== {(c >= 1 && c <= 20), (c == 21), ev, ew}) begin
                errors++;
                $display("FAIL lat1_ctrl c%0d got %b exp %b", c, {ifa.busy, ifa.done, ifa.sb_in_valid, ifa.wr_en},
                         {(c >= 1 && c <= 20), (c == 21), ev, ew});
            end
            if (ev) begin
                checks++;
                if (ifa.sb_in_idx !== 4'(c - 1)) begin
                    errors++; $display("FAIL lat1_in_idx c%0d got %0d exp %0d", c, ifa.sb_in_idx, c - 1);
                end
            end
            if (ew) begin
                checks++;
                if (ifa.wr_idx !== 4'(c - 5)) begin
                    errors++; $display("FAIL lat1_wr_idx c%0d got %0d exp %0d", c, ifa.wr_idx, c - 5);
                end
            end
            checks++;
            if (got[1] !== expv[1]) begin
                errors++; $display("FAIL lat1_model dut1 c%0d got %h exp %h", c, got[1], expv[1]);
            end
            tick();
        end
        rnd_valid = 1'b0;
    endtask

    task automatic test_bubbles();
        int nrdy = 0, nwr = 0, ndone = 0, last_wr = -1, done_c = -1;
        for (int c = 0; c < 32; c++) begin
            start = (c == 0); rnd_valid = !(c >= 3 && c <= 5);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (got[d] !== expv[d]) begin
                    errors++; $display("FAIL bubble_model dut%0d c%0d got %h exp %h", d, c, got[d], expv[d]);
                end
            end
            if (c == 6) begin
                checks++;
                if ({ifb.sb_in_valid, ifb.sb_in_idx} !== {1'b1, 4'd2}) begin
                    errors++; $display("FAIL bubble_idx2_c6 got %b/%0d exp 1/2", ifb.sb_in_valid, ifb.sb_in_idx);
                end
            end
            if (ifb.rnd_ready) nrdy++;
            if (ifb.wr_en) begin
                checks++;
                if (ifb.wr_idx !== 4'(nwr)) begin
                    errors++; $display("FAIL bubble_wr_order c%0d got %0d exp %0d", c, ifb.wr_idx, nwr);
                end
                nwr++; last_wr = c;
            end
            if (ifb.done) begin ndone++; done_c = c; end
            tick();
        end
        rnd_valid = 1'b0;
        checks++;
        if (nrdy != 16) begin errors++; $display("FAIL bubble_rnd_ready_count got %0d exp 16", nrdy); end
        checks++;
        if (nwr != 16) begin errors++; $display("FAIL bubble_wr_count got %0d exp 16", nwr); end
        checks++;
        if (ndone != 1 || done_c != last_wr + 1) begin
            errors++; $display("FAIL bubble_done got %0d pulses @c%0d exp 1 @c%0d", ndone, done_c, last_wr + 1);
        end
    endtask

    // start held through FEED/DRAIN of both DUTs, pulsed in dut1's DONE, then in its IDLE.
    task automatic test_restart();
        int nd[2] = '{0, 0};
        for (int c = 0; c < 56; c++) begin
            start = (c <= 21) || (c == 25) || (c == 26); rnd_valid = 1'b1;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (got[d] !== expv[d]) begin
                    errors++; $display("FAIL restart_model dut%0d c%0d got %h exp %h", d, c, got[d], expv[d]);
                end
                if (o_done[d]) nd[d]++;
            end
            if (c == 25) begin
                checks++;
                if ({ifb.done, ifb.busy} !== 2'b10) begin
                    errors++; $display("FAIL restart_done_c25 got %b exp 10", {ifb.done, ifb.busy});
                end
            end
            if (c == 27) begin
                checks++;
                if ({ifb.sb_in_valid, ifb.sb_in_idx} !== {1'b1, 4'd0}) begin
                    errors++; $display("FAIL restart_idx0_c27 got %b/%0d exp 1/0", ifb.sb_in_valid, ifb.sb_in_idx);
                end
            end
            tick();
        end
        start = 1'b0; rnd_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (nd[d] != 2) begin errors++; $display("FAIL restart_done_count dut%0d got %0d exp 2", d, nd[d]); end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 41; c++) begin
            start = (c == 0); rnd_valid = 1'b1; rst = (c == 10);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (got[d] !== expv[d]) begin
                    errors++; $display("FAIL rstmid_model dut%0d c%0d got %h exp %h", d, c, got[d], expv[d]);
                end
                if (c == 11) begin
                    checks++;
                    if ({got[d], o_widx[d]} !== 17'd0) begin
                        errors++; $display("FAIL rstmid_zero dut%0d got %h exp 0", d, {got[d], o_widx[d]});
                    end
                end
                if (c > 11) begin
                    checks++;
                    if ({o_wr[d], o_done[d], o_busy[d]} !== 3'b000) begin
                        errors++; $display("FAIL rstmid_quiet dut%0d c%0d got %b exp 000", d, c, {o_wr[d], o_done[d], o_busy[d]});
                    end
                end
            end
            tick();
        end
        rst = 1'b0; rnd_valid = 1'b0;
    endtask

    task automatic test_step_en();
        for (int c = 0; c < 33; c++) begin
            start = (c == 0); rnd_valid = 1'b1;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (o_step[d] !== e_step[d]) begin
                    errors++; $display("FAIL step_en dut%0d c%0d got %b exp %b", d, c, o_step[d], e_step[d]);
                end
                if (c == 0 || c >= 30) begin
                    checks++;
                    if (o_step[d] !== '0) begin
                        errors++; $display("FAIL step_en_idle dut%0d c%0d got %b exp 0", d, c, o_step[d]);
                    end
                end
            end
            tick();
        end
        rnd_valid = 1'b0;
    endtask

    task automatic test_random();
        int iss_c[2][N];
        int wcnt[2][N];
        bit seen[2];
        int k;
        for (int r = 0; r < 100; r++) begin
            for (int d = 0; d < 2; d++) begin
                seen[d] = 1'b0;
                for (int i = 0; i < N; i++) begin iss_c[d][i] = 0; wcnt[d][i] = 0; end
            end
            k = 0;
            while (!(seen[0] && seen[1]) && k < 400) begin
                start = (k == 0); rnd_valid = 1'($urandom_range(0, 1));
                @(negedge clk);
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if (got[d] !== expv[d]) begin
                        errors++; $display("FAIL rand_model r%0d dut%0d cyc%0d got %h exp %h", r, d, cyc, got[d], expv[d]);
                    end
                    if (o_valid[d] === 1'b1) iss_c[d][o_idx[d]] = cyc;
                    if (o_wr[d] === 1'b1) begin
                        wcnt[d][o_widx[d]]++;
                        checks++;
                        if (cyc - iss_c[d][o_widx[d]] != lat_of(d)) begin
                            errors++; $display("FAIL rand_latency r%0d dut%0d idx%0d got %0d exp %0d", r, d,
                                               o_widx[d], cyc - iss_c[d][o_widx[d]], lat_of(d));
                        end
                    end
                    if (o_done[d] === 1'b1) seen[d] = 1'b1;
                end
                tick();
                k++;
            end
            checks++;
            if (!(seen[0] && seen[1])) begin
                errors++; $display("FAIL rand_timeout r%0d done seen %b%b exp 11", r, seen[1], seen[0]);
            end
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (wcnt[d][i] != 1) begin
                        errors++; $display("FAIL rand_write_once r%0d dut%0d idx%0d got %0d exp 1", r, d, i, wcnt[d][i]);
                    end
                end
        end
        start = 1'b0; rnd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency1();
        test_bubbles();
        test_restart();
        test_reset_mid();
        test_step_en();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
